icap_multiboot_ctrl: RTL and testbench
======================================

Name: icap_multiboot_ctrl

Overview:
- Parametrised successor to the single-image ICAP reprogram block.
- Issues an IPROG sequence whose warm-boot start address is taken from a runtime-selected image slot (base + sel × stride), not a hard-wired zero.
- Exposes the ICAP interface as registered ports, so the ICAPE2 primitive sits in the wrapper.
- The wrapper drives ICAPE2 CLK with ~clk; it also reports busy, done and error status to slow control.

Parameters:
- NUM_DUMMY, 1, count of 0xFFFFFFFF dummy words sent before SYNC (1..15).
- NUM_IMAGES, 4, number of selectable bitstream slots (2..16).
- SEL_W, 2, width of image_sel; must satisfy 2^SEL_W ≥ NUM_IMAGES.
- IMAGE_BASE, 32'h0000_0000, flash address of slot 0.
- IMAGE_STRIDE, 32'h0040_0000, address step between slots.
- WBSTAR_RS, 2'b00, RS[1:0] field written into WBSTAR[31:30].
- WBSTAR_RS_TS_B, 1'b0, RS tristate bit written into WBSTAR[29].
- ARM_WINDOW, 1024, cycles an arm stays valid; used only with the optional feature.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- trigger, in, 1, single-cycle request to reprogram.
- image_sel, in, SEL_W, slot index; sampled on the accepted trigger.
- arm, in, 1, arm pulse; used only with the optional feature.
- icap_csib, out, 1, ICAP CSIB (active low).
- icap_rdwrb, out, 1, ICAP RDWRB; constant 0 (write).
- icap_data, out, 32, ICAP I bus, already bit-swapped within each byte.
- busy, out, 1, high from the accepted trigger until reset.
- done, out, 1, high once the final NOOP has been presented.
- err, out, 1, single-cycle pulse when a trigger is rejected.

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - state = IDLE; icap_csib = 1; icap_data = swap(0xFFFFFFFF).
  - busy = 0; done = 0; err = 0; arm state cleared.
  - Reset mid-sequence aborts at once with the same values; no partial command completes.
- Word sequence (logical value, before the byte bit-swap):
  - NUM_DUMMY × FFFFFFFF
  - AA995566 (SYNC)
  - 20000000 (NOOP)
  - 30020001 (write WBSTAR)
  - WBSTAR data word
  - 30008001 (write CMD)
  - 0000000F (IPROG)
  - 20000000 (NOOP)
- WBSTAR data word = {WBSTAR_RS, WBSTAR_RS_TS_B, addr[28:0]}.
  - addr = IMAGE_BASE + image_sel × IMAGE_STRIDE, computed modulo 2^32; bits 31:29 are discarded.
  - addr is latched into a register at trigger acceptance.
- States:
  - IDLE → DUMMY (count down NUM_DUMMY) → SYNC → NOOP1 → WR_WBSTAR → WBSTAR_DATA → WR_CMD → IPROG → NOOP2 → DONE.
  - DONE is terminal until reset; the FPGA reconfigures meanwhile.
- Timing:
  - Trigger accepted at edge T: busy = 1 after T.
  - The first dummy word appears with icap_csib = 0 after edge T+1.
  - Each subsequent word occupies exactly one cycle with csib = 0.
  - After NOOP2: icap_csib = 1, data holds NOOP, done = 1.
  - Total csib-low cycles = NUM_DUMMY + 7.
- Triggers are accepted only in IDLE; a trigger while busy is ignored with no err.
- If image_sel ≥ NUM_IMAGES on a trigger in IDLE: no sequence starts, err pulses one cycle, state stays IDLE.
- icap_data is the per-byte bit reversal of the logical word: out[8k+j] = word[8k+7−j].
- icap_rdwrb = 0 at all times.

Optional Feature:
- Macro: REPROG_ARM_EN.
- Defined:
  - An arm pulse in IDLE loads a down-counter with ARM_WINDOW.
  - A trigger is accepted only while the counter is non-zero.
  - An unarmed or expired trigger pulses err.
  - Arm and trigger in the same cycle: arm loads, the trigger is rejected with err.
  - The counter clears on acceptance.
- Undefined: the arm port is ignored and trigger acts directly.

Decomposition:
- Package icap_pkg: ICAP_DUMMY, ICAP_SYNC, ICAP_NOOP, ICAP_WR_WBSTAR, ICAP_WR_CMD, ICAP_IPROG constants, and the state encoding.
- Sub-module icap_byte_swap: combinational per-byte bit reversal, instantiated on the output register.

Test Plan:
1. Defaults, trigger with image_sel = 2:
   - csib low for 8 consecutive cycles starting the cycle after the first edge at which state = DUMMY.
   - Un-swapped data = FFFFFFFF, AA995566, 20000000, 30020001, 00800000, 30008001, 0000000F, 20000000.
   - Then csib = 1 and done = 1.
2. NUM_DUMMY = 3, NUM_IMAGES = 3, image_sel = 3:
   - err pulses one cycle, busy stays 0, csib stays 1.
   - A following trigger with sel = 1 sends 3 dummy words then address 00400000.
3. Reset_n low during WBSTAR_DATA:
   - Next cycle csib = 1, busy = 0, done = 0.
   - A new trigger replays the full sequence.
4. Second trigger pulses during the sequence:
   - Ignored; exactly one sequence is sent, err never asserts.
5. WBSTAR_RS = 2'b10, RS_TS_B = 1, IMAGE_BASE = 32'h2000_0000, sel = 0:
   - WBSTAR data = 0xA0000000; address bits 31:29 are truncated.
6. REPROG_ARM_EN, ARM_WINDOW = 4:
   - Trigger 5 cycles after arm → err.
   - Trigger 2 cycles after arm → accepted.

Source files
------------

// File: rtl/icap_pkg.sv
// -----------------------------------------------------------------------------
// icap_pkg
// Shared definitions for the multiboot ICAP reprogram controller.
//   - Logical (un-swapped) ICAP command words used by the IPROG sequence.
//   - State encoding of the sequencing FSM.
// No ports: package only.
// -----------------------------------------------------------------------------
package icap_pkg;

  localparam logic [31:0] ICAP_DUMMY     = 32'hFFFF_FFFF;
  localparam logic [31:0] ICAP_SYNC      = 32'hAA99_5566;
  localparam logic [31:0] ICAP_NOOP      = 32'h2000_0000;
  localparam logic [31:0] ICAP_WR_WBSTAR = 32'h3002_0001;
  localparam logic [31:0] ICAP_WR_CMD    = 32'h3000_8001;
  localparam logic [31:0] ICAP_IPROG     = 32'h0000_000F;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DUMMY,
    ST_SYNC,
    ST_NOOP1,
    ST_WR_WBSTAR,
    ST_WBSTAR_DATA,
    ST_WR_CMD,
    ST_IPROG,
    ST_NOOP2,
    ST_DONE
  } icap_state_t;

endpackage

// File: rtl/icap_multiboot_ctrl_byte_swap.sv
// -----------------------------------------------------------------------------
// icap_byte_swap
// Combinational per-byte bit reversal required by the ICAPE2 data bus:
// swapped[8k+j] = word[8k+7-j].
// Ports:
//   word    in  32  logical command word
//   swapped out 32  bit-swapped word for the ICAP I bus
// -----------------------------------------------------------------------------
module icap_byte_swap (
  input  logic [31:0] word,
  output logic [31:0] swapped
);

  always_comb begin
    swapped = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        swapped[8*k+j] = word[8*k+7-j];
      end
    end
  end

endmodule

// File: rtl/icap_multiboot_ctrl.sv
// -----------------------------------------------------------------------------
// icap_multiboot_ctrl
// Issues an IPROG sequence through registered ICAP ports. The warm-boot start
// address comes from a runtime-selected image slot:
// IMAGE_BASE + image_sel * IMAGE_STRIDE (modulo 2^32, bits 31:29 dropped).
// The ICAPE2 primitive lives in the wrapper, which clocks it with ~clk.
//
// Optional feature macro: REPROG_ARM_EN
//   Defined  : a trigger is only accepted within ARM_WINDOW cycles of an arm
//              pulse seen in IDLE; otherwise the trigger is rejected with err.
//   Undefined: arm is ignored and trigger acts directly.
//
// Ports:
//   clk        in   1      system clock
//   reset_n    in   1      synchronous active-low reset
//   trigger    in   1      single-cycle reprogram request
//   image_sel  in   SEL_W  slot index, sampled on the accepted trigger
//   arm        in   1      arm pulse (REPROG_ARM_EN only)
//   icap_csib  out  1      ICAP chip select, active low
//   icap_rdwrb out  1      ICAP read/write select, always write (0)
//   icap_data  out  32     ICAP I bus, bit-swapped within each byte
//   busy       out  1      high from accepted trigger until reset
//   done       out  1      high once the final NOOP has been presented
//   err        out  1      one-cycle pulse when a trigger is rejected
// -----------------------------------------------------------------------------
module icap_multiboot_ctrl
  import icap_pkg::*;
#(
  parameter int unsigned NUM_DUMMY      = 1,
  parameter int unsigned NUM_IMAGES     = 4,
  parameter int unsigned SEL_W          = 2,
  parameter logic [31:0] IMAGE_BASE     = 32'h0000_0000,
  parameter logic [31:0] IMAGE_STRIDE   = 32'h0040_0000,
  parameter logic [1:0]  WBSTAR_RS      = 2'b00,
  parameter logic        WBSTAR_RS_TS_B = 1'b0,
  parameter int unsigned ARM_WINDOW     = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trigger,
  input  logic [SEL_W-1:0] image_sel,
  input  logic             arm,
  output logic             icap_csib,
  output logic             icap_rdwrb,
  output logic [31:0]      icap_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  icap_state_t state;
  logic [3:0]  dummy_cnt;
  logic [31:0] wbstar_word;
  logic [31:0] word;
  logic [31:0] slot_addr;
  logic        sel_ok;
  logic        armed;
  logic        accept;

  assign icap_rdwrb = 1'b0;
  assign sel_ok     = 32'(image_sel) < 32'(NUM_IMAGES);
  assign slot_addr  = IMAGE_BASE + 32'(image_sel) * IMAGE_STRIDE;
  assign accept     = (state == ST_IDLE) && trigger && sel_ok && armed;

`ifdef REPROG_ARM_EN
  localparam int unsigned ARM_CW = $clog2(ARM_WINDOW + 1);
  logic [ARM_CW-1:0] arm_cnt;

  // An arm in the same cycle as a trigger reloads the window but does not
  // count as armed for that trigger.
  assign armed = (arm_cnt != '0) && !arm;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (arm)
        arm_cnt <= ARM_CW'(ARM_WINDOW);
      else if (accept)
        arm_cnt <= '0;
      else if (arm_cnt != '0)
        arm_cnt <= arm_cnt - 1'b1;
    end else begin
      arm_cnt <= '0;
    end
  end
`else
  logic unused_arm;
  assign armed      = 1'b1;
  assign unused_arm = arm ^ ARM_WINDOW[0];
`endif

  // Each state presents its word at the next edge, so the output register
  // lags the state by one cycle; DONE leaves the last NOOP on the bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      icap_csib   <= 1'b1;
      word        <= ICAP_DUMMY;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      dummy_cnt   <= '0;
      wbstar_word <= '0;
    end else begin
      err <= (state == ST_IDLE) && trigger && !accept;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_DUMMY;
            busy        <= 1'b1;
            dummy_cnt   <= 4'(NUM_DUMMY);
            wbstar_word <= {WBSTAR_RS, WBSTAR_RS_TS_B, slot_addr[28:0]};
          end
        end
        ST_DUMMY: begin
          icap_csib <= 1'b0;
          word      <= ICAP_DUMMY;
          dummy_cnt <= dummy_cnt - 4'd1;
          if (dummy_cnt == 4'd1)
            state <= ST_SYNC;
        end
        ST_SYNC: begin
          icap_csib <= 1'b0;
          word      <= ICAP_SYNC;
          state     <= ST_NOOP1;
        end
        ST_NOOP1: begin
          icap_csib <= 1'b0;
          word      <= ICAP_NOOP;
          state     <= ST_WR_WBSTAR;
        end
        ST_WR_WBSTAR: begin
          icap_csib <= 1'b0;
          word      <= ICAP_WR_WBSTAR;
          state     <= ST_WBSTAR_DATA;
        end
        ST_WBSTAR_DATA: begin
          icap_csib <= 1'b0;
          word      <= wbstar_word;
          state     <= ST_WR_CMD;
        end
        ST_WR_CMD: begin
          icap_csib <= 1'b0;
          word      <= ICAP_WR_CMD;
          state     <= ST_IPROG;
        end
        ST_IPROG: begin
          icap_csib <= 1'b0;
          word      <= ICAP_IPROG;
          state     <= ST_NOOP2;
        end
        ST_NOOP2: begin
          icap_csib <= 1'b0;
          word      <= ICAP_NOOP;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          icap_csib <= 1'b1;
          done      <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  icap_byte_swap u_byte_swap (
    .word    (word),
    .swapped (icap_data)
  );

endmodule

// File: tb/tb_icap_multiboot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icap_multiboot_ctrl
// Drives three differently parameterised controllers with shared stimulus
// (directed scenarios, then random) and compares every output each cycle
// against a cycle-count reference model per instance.
//   dut0: defaults
//   dut1: NUM_DUMMY=3, NUM_IMAGES=3
//   dut2: WBSTAR_RS=2'b10, WBSTAR_RS_TS_B=1, IMAGE_BASE=32'h2000_0000
// All use ARM_WINDOW=4; the arm window is modelled when REPROG_ARM_EN is set.
// -----------------------------------------------------------------------------
module tb_icap_multiboot_ctrl;

  localparam int NDUT = 3;
  localparam int TB_ARM_WINDOW = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       trigger = 1'b0;
  logic [1:0] image_sel = 2'd0;
  logic       arm = 1'b0;

  logic [NDUT-1:0] csib, rdwrb, busy, done, err;
  logic [31:0]     data [NDUT];

  int assertCount = 0;
  int failCount   = 0;
  int cycle       = 0;

  // Reference model state
  bit          active   [NDUT];
  int          k        [NDUT];
  bit          errExp   [NDUT];
  logic [31:0] lastWord [NDUT];
  logic [31:0] wbExp    [NDUT];
  bit          armValid [NDUT];
  int          armAt    [NDUT];

  always #5 clk = ~clk;

  icap_multiboot_ctrl #(.ARM_WINDOW(TB_ARM_WINDOW)) dut0 (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .image_sel(image_sel), .arm(arm),
    .icap_csib(csib[0]), .icap_rdwrb(rdwrb[0]), .icap_data(data[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  icap_multiboot_ctrl #(.NUM_DUMMY(3), .NUM_IMAGES(3), .ARM_WINDOW(TB_ARM_WINDOW)) dut1 (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .image_sel(image_sel), .arm(arm),
    .icap_csib(csib[1]), .icap_rdwrb(rdwrb[1]), .icap_data(data[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  icap_multiboot_ctrl #(.WBSTAR_RS(2'b10), .WBSTAR_RS_TS_B(1'b1), .IMAGE_BASE(32'h2000_0000),
                        .ARM_WINDOW(TB_ARM_WINDOW)) dut2 (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .image_sel(image_sel), .arm(arm),
    .icap_csib(csib[2]), .icap_rdwrb(rdwrb[2]), .icap_data(data[2]),
    .busy(busy[2]), .done(done[2]), .err(err[2])
  );

  function automatic int ndOf(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic int niOf(input int i);
    return (i == 1) ? 3 : 4;
  endfunction

  // WBSTAR data word straight from the slot arithmetic
  function automatic logic [31:0] wbstarOf(input int i, input int sel);
    logic [31:0] base, addr;
    logic [2:0]  top;
    base = (i == 2) ? 32'h2000_0000 : 32'h0000_0000;
    top  = (i == 2) ? 3'b101 : 3'b000;
    addr = base + 32'(sel) * 32'h0040_0000;
    return {top, addr[28:0]};
  endfunction

  function automatic logic [31:0] swapBytes(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 8; j++)
        r[8*b+j] = w[8*b+7-j];
    return r;
  endfunction

  // p-th word of the sequence for instance i (p counts from 0)
  function automatic logic [31:0] seqWord(input int i, input int p);
    int q;
    if (p < ndOf(i)) return 32'hFFFF_FFFF;
    q = p - ndOf(i);
    case (q)
      0:       return 32'hAA99_5566;
      1:       return 32'h2000_0000;
      2:       return 32'h3002_0001;
      3:       return wbExp[i];
      4:       return 32'h3000_8001;
      5:       return 32'h0000_000F;
      default: return 32'h2000_0000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cycle, got, exp);
    end
  endtask

  task automatic updateModel(input int i, input bit rst, input bit trg, input int sel, input bit armIn);
    if (!rst) begin
      active[i]   = 1'b0;
      k[i]        = 0;
      errExp[i]   = 1'b0;
      lastWord[i] = 32'hFFFF_FFFF;
      armValid[i] = 1'b0;
    end else begin
      errExp[i] = 1'b0;
      if (active[i]) begin
        k[i]++;
        if (k[i] >= 1 && k[i] <= ndOf(i) + 7)
          lastWord[i] = seqWord(i, k[i] - 1);
      end else begin
        bit ok;
        ok = trg;
`ifdef REPROG_ARM_EN
        if (armIn) begin
          ok = 1'b0;
          if (trg) errExp[i] = 1'b1;
          armValid[i] = 1'b1;
          armAt[i]    = cycle;
        end else if (trg && !(armValid[i] && (cycle - armAt[i]) <= TB_ARM_WINDOW)) begin
          ok = 1'b0;
          errExp[i] = 1'b1;
        end
`endif
        if (ok) begin
          if (sel >= niOf(i)) begin
            errExp[i] = 1'b1;
          end else begin
            active[i]   = 1'b1;
            k[i]        = 0;
            wbExp[i]    = wbstarOf(i, sel);
            armValid[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit trg, input int sel, input bit armIn);
    @(negedge clk);
    reset_n   = rst;
    trigger   = trg;
    image_sel = 2'(sel);
    arm       = armIn;
    @(posedge clk);
    cycle++;
    for (int i = 0; i < NDUT; i++) updateModel(i, rst, trg, sel, armIn);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      bit lowExp;
      lowExp = active[i] && k[i] >= 1 && k[i] <= ndOf(i) + 7;
      checkOutput($sformatf("csib%0d", i), 32'(csib[i]), 32'(!lowExp));
      checkOutput($sformatf("data%0d", i), data[i], swapBytes(lastWord[i]));
      checkOutput($sformatf("busy%0d", i), 32'(busy[i]), 32'(active[i]));
      checkOutput($sformatf("done%0d", i), 32'(done[i]), 32'(active[i] && k[i] > ndOf(i) + 7));
      checkOutput($sformatf("err%0d", i), 32'(err[i]), 32'(errExp[i]));
      checkOutput($sformatf("rdwrb%0d", i), 32'(rdwrb[i]), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
  endtask

  // In the arm build every directed trigger is preceded by an arm pulse
  task automatic fire(input int sel);
`ifdef REPROG_ARM_EN
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
`endif
    applyStimulus(1'b1, 1'b1, sel, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    doReset();
    idle(2);

    // Default slot 2 sequence, then done
    fire(2);
    idle(14);

    // Out-of-range slot for the 3-image instance, then a valid retry
    doReset();
    fire(3);
    idle(14);
    fire(1);
    idle(14);

    // Reset while the WBSTAR data word is being issued, then full replay
    doReset();
    fire(2);
    idle(4);
    doReset();
    fire(2);
    idle(14);

    // Repeated triggers during a running sequence are ignored
    doReset();
    fire(0);
    idle(2);
    applyStimulus(1'b1, 1'b1, 2, 1'b0);
    idle(3);
    applyStimulus(1'b1, 1'b1, 1, 1'b0);
    idle(12);

`ifdef REPROG_ARM_EN
    // Arm window: trigger too late, then trigger in time
    doReset();
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    idle(4);
    applyStimulus(1'b1, 1'b1, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    idle(1);
    applyStimulus(1'b1, 1'b1, 0, 1'b0);
    idle(14);
    // Arm and trigger in the same cycle
    doReset();
    applyStimulus(1'b1, 1'b1, 0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1, 1'b0);
    idle(14);
`endif

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 99) != 0,
                    $urandom_range(0, 5) == 0,
                    int'($urandom_range(0, 3)),
                    $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
